// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
//
// Shares the single Avalon-MM master port of the SDRAM controller between two
// requesters:
//   * the VGA pixel-fetch engine, which asks for fixed-length read bursts and
//     has absolute priority (a late pixel is a visible glitch), and
//   * the CPU/draw requester, which issues single Avalon reads and writes.
//
// Every read accepted by the SDRAM controller pushes a one-bit owner tag into
// a small FIFO. Read data returns in issue order, so the FIFO head always
// names the owner of the next m_readdatavalid beat. The beat is forwarded to
// that owner one cycle later.
//
// Ports
//   clk_clk, reset_reset          clock, synchronous active-high reset
//   vga_req / vga_addr / vga_gnt  burst request (level), base word address,
//                                 one-cycle grant pulse
//   vga_rdata / vga_rvalid        read data returned to the VGA engine
//   cpu_read / cpu_write / cpu_addr / cpu_wdata / cpu_be / cpu_waitrequest
//                                 Avalon-MM slave face presented to the CPU
//   cpu_rdata / cpu_rvalid        read data returned to the CPU
//   m_*                           Avalon-MM master toward the SDRAM controller
//   err_orphan                    sticky: read data arrived with no owner
// -----------------------------------------------------------------------------
module sdram_port_arbiter #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 8,
    parameter int MAX_OUTST = 8
) (
    input  logic                clk_clk,
    input  logic                reset_reset,

    input  logic                vga_req,
    input  logic [ADDR_W-1:0]   vga_addr,
    output logic                vga_gnt,
    output logic [DATA_W-1:0]   vga_rdata,
    output logic                vga_rvalid,

    input  logic                cpu_read,
    input  logic                cpu_write,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_be,
    output logic                cpu_waitrequest,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_rvalid,

    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,

    output logic                err_orphan
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int BC_W  = $clog2(BURST_LEN + 1);

    // A burst is only granted when its full length fits in the tag FIFO, so
    // the burst itself can never overflow it.
    localparam logic [CNT_W-1:0] VGA_LIMIT  = CNT_W'(MAX_OUTST - BURST_LEN);
    localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(MAX_OUTST);
    localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(BURST_LEN - 1);

    localparam logic TAG_CPU = 1'b0;
    localparam logic TAG_VGA = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        VGA_BURST = 2'd1,
        CPU_ACC   = 2'd2
    } state_t;

    state_t state;

    logic [BC_W-1:0]  burst_cnt;

    logic             tag_mem [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] tag_cnt;

    logic             m_accept_p0;
    logic             tag_push_p0;
    logic             tag_push_val_p0;
    logic             tag_pop_p0;
    logic             orphan_p0;
    logic             ret_vga_p0;
    logic             ret_cpu_p0;

    // -------------------------------------------------------------------------
    // Command stage: decisions made on the current master-port cycle
    // -------------------------------------------------------------------------
    // m_read/m_write are registered, so an accepted command is simply an
    // asserted command with waitrequest low.
    assign m_accept_p0     = (m_read | m_write) & ~m_waitrequest;
    assign tag_push_p0     = m_read & ~m_waitrequest;
    assign tag_push_val_p0 = (state == VGA_BURST) ? TAG_VGA : TAG_CPU;

    assign tag_pop_p0      = m_readdatavalid & (tag_cnt != '0);
    assign orphan_p0       = m_readdatavalid & (tag_cnt == '0);
    assign ret_vga_p0      = tag_pop_p0 & (tag_mem[rd_ptr] == TAG_VGA);
    assign ret_cpu_p0      = tag_pop_p0 & (tag_mem[rd_ptr] == TAG_CPU);

    // The CPU may only see waitrequest low in the very cycle its latched
    // command is taken by the SDRAM controller.
    assign cpu_waitrequest = ~((state == CPU_ACC) & ~m_waitrequest);

    // -------------------------------------------------------------------------
    // Arbitration FSM and master-port command registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state        <= IDLE;
            burst_cnt    <= '0;
            vga_gnt      <= 1'b0;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_address    <= '0;
            m_writedata  <= '0;
            m_byteenable <= '0;
        end else begin
            vga_gnt <= 1'b0;
            case (state)
                IDLE: begin
                    if (vga_req && (tag_cnt <= VGA_LIMIT)) begin
                        vga_gnt      <= 1'b1;
                        m_read       <= 1'b1;
                        m_address    <= vga_addr;
                        m_byteenable <= {BE_W{1'b1}};
                        burst_cnt    <= '0;
                        state        <= VGA_BURST;
                    end else if (cpu_read && (tag_cnt < FIFO_FULL)) begin
                        // A read+write collision is served as a read; it also
                        // waits for tag space rather than falling back to a write.
                        m_read       <= 1'b1;
                        m_address    <= cpu_addr;
                        m_writedata  <= cpu_wdata;
                        m_byteenable <= cpu_be;
                        state        <= CPU_ACC;
                    end else if (cpu_write && !cpu_read) begin
                        m_write      <= 1'b1;
                        m_address    <= cpu_addr;
                        m_writedata  <= cpu_wdata;
                        m_byteenable <= cpu_be;
                        state        <= CPU_ACC;
                    end
                end

                VGA_BURST: begin
                    if (!m_waitrequest) begin
                        // Address increments only on acceptance so stalls never
                        // skip or repeat a word; it wraps at 2^ADDR_W naturally.
                        m_address <= m_address + 1'b1;
                        burst_cnt <= burst_cnt + 1'b1;
                        if (burst_cnt == BURST_LAST) begin
                            m_read <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end

                CPU_ACC: begin
                    if (!m_waitrequest) begin
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    m_read  <= 1'b0;
                    m_write <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Tag FIFO: owner of every outstanding read, in issue order
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            if (tag_push_p0) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (tag_pop_p0) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({tag_push_p0, tag_pop_p0})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // Tag storage holds no control state; the pointers define what is valid.
    always_ff @(posedge clk_clk) begin
        if (tag_push_p0) begin
            tag_mem[wr_ptr] <= tag_push_val_p0;
        end
    end

    // -------------------------------------------------------------------------
    // Return stage _p1: route each beat to its owner one cycle after arrival
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            vga_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            vga_rvalid <= ret_vga_p0;
            cpu_rvalid <= ret_cpu_p0;
            if (orphan_p0) begin
                err_orphan <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (ret_vga_p0) begin
            vga_rdata <= m_readdata;
        end
        if (ret_cpu_p0) begin
            cpu_rdata <= m_readdata;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

    localparam int ADDR_W    = 24;
    localparam int DATA_W    = 16;
    localparam int BURST_LEN = 8;
    localparam int MAX_OUTST = 8;
    localparam int BE_W      = DATA_W / 8;

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;
    logic              cpu_read;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [BE_W-1:0]   cpu_be;
    logic              cpu_waitrequest;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_write;
    logic [DATA_W-1:0] m_writedata;
    logic [BE_W-1:0]   m_byteenable;
    logic              m_waitrequest   = 1'b0;
    logic [DATA_W-1:0] m_readdata      = '0;
    logic              m_readdatavalid = 1'b0;
    logic              err_orphan;

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_waitrequest(cpu_waitrequest),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .err_orphan(err_orphan)
    );

    always #5 clk_clk = ~clk_clk;

    // ---------------- memory contents and reference model ----------------
    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ {a[23:16], 8'hC3} ^ 16'h5A00;
    endfunction

    logic [DATA_W-1:0] smem [int];   // contents held by the SDRAM bus model
    logic [DATA_W-1:0] rmem [int];   // contents predicted from issued commands

    function automatic logic [DATA_W-1:0] sread(input logic [ADDR_W-1:0] a);
        return smem.exists(int'(a)) ? smem[int'(a)] : init_word(a);
    endfunction

    function automatic logic [DATA_W-1:0] rread(input logic [ADDR_W-1:0] a);
        return rmem.exists(int'(a)) ? rmem[int'(a)] : init_word(a);
    endfunction

    // ---------------- SDRAM controller bus model ----------------
    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } ret_t;

    ret_t rq[$];
    int   lat       = 3;
    bit   stall_en  = 1'b0;
    int   hold_at   = -1;
    int   acc_total = 0;
    int   scyc      = 0;

    always @(posedge clk_clk) begin
        logic [DATA_W-1:0] old;
        if (m_read && !m_waitrequest) begin
            rq.push_back('{due: scyc + lat, data: sread(m_address)});
            acc_total++;
        end
        if (m_write && !m_waitrequest) begin
            old = sread(m_address);
            smem[int'(m_address)] = {m_byteenable[1] ? m_writedata[15:8] : old[15:8],
                                     m_byteenable[0] ? m_writedata[7:0]  : old[7:0]};
        end
        scyc++;
        #2;
        if (hold_at >= 0 && acc_total >= hold_at)
            m_waitrequest = 1'b1;
        else
            m_waitrequest = stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
        if (rq.size() > 0 && rq[0].due <= scyc) begin
            m_readdatavalid = 1'b1;
            m_readdata      = rq[0].data;
            void'(rq.pop_front());
        end else begin
            m_readdatavalid = 1'b0;
            m_readdata      = DATA_W'($urandom);
        end
    end

    // ---------------- observation ----------------
    logic [DATA_W-1:0] vga_got[$];
    logic [DATA_W-1:0] cpu_got[$];
    logic [ADDR_W-1:0] rd_addr[$];
    int                rd_cyc[$];
    int                mcyc = 0, wrl_cnt = 0, wr_cnt = 0, wr_acc_rdpos = 0;
    int                outst = 0, max_outst = 0;

    always @(posedge clk_clk) begin
        mcyc++;
        if (vga_rvalid) vga_got.push_back(vga_rdata);
        if (cpu_rvalid) cpu_got.push_back(cpu_rdata);
        if (!cpu_waitrequest) wrl_cnt++;
        if (m_read && !m_waitrequest) begin
            rd_addr.push_back(m_address);
            rd_cyc.push_back(mcyc);
            outst++;
        end
        if (m_write && !m_waitrequest) begin
            wr_cnt++;
            wr_acc_rdpos = rd_addr.size();
        end
        if (m_readdatavalid && outst > 0) outst--;
        if (outst > max_outst) max_outst = outst;
    end

    // ---------------- checking helpers ----------------
    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] exp_vga[$];
    logic [DATA_W-1:0] exp_cpu[$];
    logic [ADDR_W-1:0] wr_addrs[$];
    int                vchk = 0, cchk = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic vga_start(input logic [ADDR_W-1:0] base, input bit expect_data,
                             input string tag, output int gnt_lat);
        gnt_lat  = -1;
        vga_req  = 1'b1;
        vga_addr = base;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk_clk);
            if (vga_gnt) begin
                gnt_lat = k;
                break;
            end
        end
        vga_req  = 1'b0;
        vga_addr = ADDR_W'($urandom);
        chk({tag, " grant seen"}, 64'(gnt_lat > 0), 64'(1));
        if (expect_data && gnt_lat > 0)
            for (int i = 0; i < BURST_LEN; i++)
                exp_vga.push_back(rread(base + ADDR_W'(i)));
    endtask

    // mode 0 = read, 1 = write, 2 = read and write raised together
    task automatic cpu_op(input int mode, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be,
                          input string tag);
        bit                acc;
        logic [DATA_W-1:0] old;
        acc       = 1'b0;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_be    = be;
        cpu_read  = (mode != 1);
        cpu_write = (mode != 0);
        for (int k = 0; k < 300; k++) begin
            if (!cpu_waitrequest) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk_clk);
        end
        @(negedge clk_clk);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        chk({tag, " accepted"}, 64'(acc), 64'(1));
        if (mode == 1) begin
            old = rread(a);
            rmem[int'(a)] = {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
            wr_addrs.push_back(a);
        end else begin
            exp_cpu.push_back(rread(a));
        end
    endtask

    task automatic drain(input string tag);
        int quiet;
        quiet = 0;
        for (int k = 0; k < 1000 && quiet < 4; k++) begin
            @(negedge clk_clk);
            if (rq.size() == 0 && !m_read && !m_write) quiet++;
            else quiet = 0;
        end
        chk({tag, " drained"}, 64'(quiet >= 4), 64'(1));
        @(negedge clk_clk);
    endtask

    task automatic check_returns(input string tag);
        chk({tag, " vga return count"}, 64'(vga_got.size() - vchk), 64'(exp_vga.size() - vchk));
        for (int i = vchk; i < exp_vga.size() && i < vga_got.size(); i++)
            chk($sformatf("%s vga data %0d", tag, i - vchk), 64'(vga_got[i]), 64'(exp_vga[i]));
        vchk = (exp_vga.size() > vga_got.size()) ? exp_vga.size() : vga_got.size();
        chk({tag, " cpu return count"}, 64'(cpu_got.size() - cchk), 64'(exp_cpu.size() - cchk));
        for (int i = cchk; i < exp_cpu.size() && i < cpu_got.size(); i++)
            chk($sformatf("%s cpu data %0d", tag, i - cchk), 64'(cpu_got[i]), 64'(exp_cpu[i]));
        cchk = (exp_cpu.size() > cpu_got.size()) ? exp_cpu.size() : cpu_got.size();
    endtask

    // ---------------- directed + randomized sequence ----------------
    initial begin
        int                gl, r0, wl0, w0, v0, c0, wc0, op;
        bit                seen;
        logic [ADDR_W-1:0] a;

        reset_reset = 1'b1;
        vga_req     = 1'b0;
        vga_addr    = '0;
        cpu_read    = 1'b0;
        cpu_write   = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;
        cpu_be      = '0;
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;

        // Reset state held through 10 idle cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_clk);
            chk("idle cmds", 64'({m_read, m_write, vga_gnt}), 64'(0));
            chk("idle m_address/data/be", 64'({m_address, m_writedata, m_byteenable}), 64'(0));
            chk("idle rvalid/err", 64'({vga_rvalid, cpu_rvalid, err_orphan}), 64'(0));
            chk("idle cpu_waitrequest", 64'(cpu_waitrequest), 64'(1));
        end

        // Single VGA burst, no stalls, latency 3
        r0 = rd_addr.size();
        vga_start(24'h000100, 1'b1, "burst100", gl);
        chk("burst100 grant latency", 64'(gl), 64'(1));
        drain("burst100");
        chk("burst100 issued", 64'(rd_addr.size() - r0), 64'(BURST_LEN));
        for (int i = 0; i < BURST_LEN && r0 + i < rd_addr.size(); i++) begin
            chk($sformatf("burst100 addr %0d", i), 64'(rd_addr[r0 + i]), 64'(24'h000100 + i));
            if (i > 0)
                chk($sformatf("burst100 back-to-back %0d", i),
                    64'(rd_cyc[r0 + i] - rd_cyc[r0 + i - 1]), 64'(1));
        end
        check_returns("burst100");

        // VGA and CPU write raised together: VGA first, then one write
        r0  = rd_addr.size();
        wl0 = wrl_cnt;
        cpu_addr  = 24'h002000;
        cpu_wdata = 16'hBEEF;
        cpu_be    = 2'b11;
        cpu_write = 1'b1;
        vga_start(24'h000300, 1'b1, "collide", gl);
        cpu_op(1, 24'h002000, 16'hBEEF, 2'b11, "collide write");
        drain("collide");
        chk("collide reads before write", 64'(wr_acc_rdpos - r0), 64'(BURST_LEN));
        chk("collide waitrequest low cycles", 64'(wrl_cnt - wl0), 64'(1));
        chk("collide mem[2000]", 64'(sread(24'h002000)), 64'(16'hBEEF));
        check_returns("collide");

        // Read and write together are served as a read
        wc0 = wr_cnt;
        cpu_op(2, 24'h002000, 16'h1234, 2'b11, "rdwr");
        drain("rdwr");
        chk("rdwr no write issued", 64'(wr_cnt - wc0), 64'(0));
        check_returns("rdwr");

        // Address wrap with random stalls
        stall_en = 1'b1;
        r0 = rd_addr.size();
        vga_start(24'hFFFFFC, 1'b1, "wrap", gl);
        drain("wrap");
        chk("wrap issued", 64'(rd_addr.size() - r0), 64'(BURST_LEN));
        for (int i = 0; i < BURST_LEN && r0 + i < rd_addr.size(); i++)
            chk($sformatf("wrap addr %0d", i), 64'(rd_addr[r0 + i]),
                64'((24'hFFFFFC + i) & 24'hFFFFFF));
        check_returns("wrap");

        // CPU read between bursts, its return overlapping the next burst
        c0 = cpu_got.size();
        v0 = vga_got.size();
        vga_start(24'h000500, 1'b1, "ilv vga a", gl);
        cpu_op(0, 24'h000040, '0, 2'b11, "ilv cpu read");
        vga_start(24'h000600, 1'b1, "ilv vga b", gl);
        drain("ilv");
        chk("ilv cpu rvalid count", 64'(cpu_got.size() - c0), 64'(1));
        chk("ilv vga rvalid count", 64'(vga_got.size() - v0), 64'(2 * BURST_LEN));
        check_returns("ilv");

        // Randomized traffic: varying latency, stalls and command mix
        for (int n = 0; n < 14; n++) begin
            lat      = $urandom_range(1, 12);
            stall_en = 1'($urandom_range(0, 1));
            op       = $urandom_range(0, 2);
            a        = 24'h000040 + ADDR_W'($urandom_range(0, 7));
            case (op)
                0: vga_start(ADDR_W'($urandom), 1'b1, "rnd vga", gl);
                1: cpu_op(1, a, DATA_W'($urandom), BE_W'($urandom_range(1, 3)), "rnd write");
                default: cpu_op(0, a, '0, 2'b11, "rnd read");
            endcase
        end
        drain("rnd");
        check_returns("rnd");
        foreach (wr_addrs[i])
            chk($sformatf("mem[%0h]", wr_addrs[i]), 64'(sread(wr_addrs[i])), 64'(rread(wr_addrs[i])));

        // Reset after three reads of a burst are accepted: returns are orphaned
        lat      = 8;
        stall_en = 1'b0;
        r0       = rd_addr.size();
        v0       = vga_got.size();
        c0       = cpu_got.size();
        hold_at  = acc_total + 3;
        vga_start(24'h000800, 1'b0, "orphan", gl);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (rd_addr.size() >= r0 + 3) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_clk);
        end
        chk("orphan three accepted", 64'(seen), 64'(1));
        reset_reset = 1'b1;
        @(negedge clk_clk);
        reset_reset = 1'b0;
        hold_at     = -1;
        chk("orphan err after reset", 64'(err_orphan), 64'(0));
        drain("orphan");
        chk("orphan issued", 64'(rd_addr.size() - r0), 64'(3));
        chk("orphan no vga rvalid", 64'(vga_got.size() - v0), 64'(0));
        chk("orphan no cpu rvalid", 64'(cpu_got.size() - c0), 64'(0));
        chk("orphan err set", 64'(err_orphan), 64'(1));
        repeat (5) @(negedge clk_clk);
        chk("orphan err sticky", 64'(err_orphan), 64'(1));
        reset_reset = 1'b1;
        @(negedge clk_clk);
        reset_reset = 1'b0;
        @(negedge clk_clk);
        chk("orphan err cleared by reset", 64'(err_orphan), 64'(0));
        chk("final cpu_waitrequest", 64'(cpu_waitrequest), 64'(1));

        chk("max outstanding reads", 64'(max_outst <= MAX_OUTST), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
